jtag_debug_cmd_sync: RTL and testbench

- System-clock half of the Nios II JTAG debug path, generalised.
- Synchronises the virtual-JTAG update-IR and update-DR strobes into the clk domain, then captures the IR code and the shift register contents.
- Dispatches one-hot take_action / take_no_action pulses to the OCI debug logic through a ready handshake.
- Replaces fixed-width, fixed-command glue: SR width, IR width and synchroniser depth are parameters; adds back-pressure and overrun detection.

---
 rtl/jtag_debug_pkg.sv | 28 ++
 rtl/jtag_debug_strobe_sync.sv | 31 +++
 rtl/jtag_debug_cmd_sync.sv | 141 ++++++++++++++
 tb/tb_jtag_debug_cmd_sync.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_debug_pkg.sv
// Purpose : shared constants for the JTAG debug command synchroniser.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: FSM state encodings, synchroniser depth bounds, action-bit index helper.
package jtag_debug_pkg;

  // FSM state encodings
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_PENDING = 1'b1;

  // Legal synchroniser depth range
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  // Depth actually built: out-of-range requests are clamped into the legal range.
  function automatic int clamp_stages(input int stages);
    if (stages < SYNC_MIN) return SYNC_MIN;
    if (stages > SYNC_MAX) return SYNC_MAX;
    return stages;
  endfunction

  // The MSB of the captured DR selects action vs no-action.
  function automatic int action_bit(input int sr_width);
    return sr_width - 1;
  endfunction

endpackage

// File: rtl/jtag_debug_strobe_sync.sv
// Purpose : STAGES-flop synchroniser for a TCK-domain level plus a rising-edge detector.
// Latency : rise is high during the cycle after edge STAGES when async_in is first seen high at edge 1.
// Backpressure: none; one single-cycle rise pulse per input rising edge.
// Ports   : clk, reset (async active-high), async_in (raw level), rise (1-cycle pulse).
module jtag_debug_strobe_sync
  import jtag_debug_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], async_in};
      prev <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// Purpose : system-clock half of the JTAG debug path; synchronises update-IR/DR strobes,
//           captures IR code and DR contents, and dispatches one-hot action pulses.
// Latency : vs_udr seen at edge 1 -> jdo valid after edge SYNC_STAGES+1 -> pulse after edge SYNC_STAGES+2.
// Backpressure: a captured command waits in PENDING for cmd_ready; DR updates arriving
//           meanwhile are dropped and flagged in the sticky overrun bit.
// Ports   : clk, reset (async active-high), vs_uir/vs_udr (TCK strobes), ir_in, sr,
//           cmd_ready, overrun_clr -> jdo, jdo_ir, take_action, take_no_action,
//           cmd_pending, overrun.
// Option  : define JTAG_DEBUG_CMD_COUNT_EN to add cmd_count[15:0] (wrapping dispatch
//           counter) and drop_count[7:0] (saturating drop counter, cleared by overrun_clr).
module jtag_debug_cmd_sync
  import jtag_debug_pkg::*;
#(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  localparam int NUM_CMDS   = 2**IR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vs_uir,
  input  logic                vs_udr,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  input  logic                cmd_ready,
  input  logic                overrun_clr,
  output logic [SR_WIDTH-1:0] jdo,
  output logic [IR_WIDTH-1:0] jdo_ir,
  output logic [NUM_CMDS-1:0] take_action,
  output logic [NUM_CMDS-1:0] take_no_action,
  output logic                cmd_pending,
  output logic                overrun
`ifdef JTAG_DEBUG_CMD_COUNT_EN
  ,
  output logic [15:0]         cmd_count,
  output logic [7:0]          drop_count
`endif
);

  localparam int STAGES  = clamp_stages(SYNC_STAGES);
  localparam int ACT_BIT = action_bit(SR_WIDTH);

  logic                uir_rise;
  logic                udr_rise;
  logic [IR_WIDTH-1:0] ir_q;
  state_t              state;
  logic                dispatch;
  logic                accept;
  logic                drop;
  logic [NUM_CMDS-1:0] sel;

  jtag_debug_strobe_sync #(.STAGES(STAGES)) u_uir_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_uir),
    .rise     (uir_rise)
  );

  jtag_debug_strobe_sync #(.STAGES(STAGES)) u_udr_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_udr),
    .rise     (udr_rise)
  );

  assign cmd_pending = (state == ST_PENDING);
  assign dispatch    = cmd_pending & cmd_ready;
  // A capture is accepted when the holding slot is empty or is emptied this very cycle.
  assign accept      = udr_rise & (~cmd_pending | dispatch);
  assign drop        = udr_rise & cmd_pending & ~cmd_ready;
  assign sel         = NUM_CMDS'(1) << jdo_ir;

  // IR code register; a same-cycle capture still sees the previous value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
    end else if (uir_rise) begin
      ir_q <= ir_in;
    end
  end

  // Command holding register and FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      jdo    <= '0;
      jdo_ir <= '0;
    end else if (accept) begin
      state  <= ST_PENDING;
      jdo    <= sr;
      jdo_ir <= ir_q;
    end else if (dispatch) begin
      state  <= ST_IDLE;
    end
  end

  // Registered one-hot pulses: only one of the two vectors can carry the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= {NUM_CMDS{dispatch &  jdo[ACT_BIT]}} & sel;
      take_no_action <= {NUM_CMDS{dispatch & ~jdo[ACT_BIT]}} & sel;
    end
  end

  // Sticky overrun; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef JTAG_DEBUG_CMD_COUNT_EN
  // Dispatch counter wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_count <= '0;
    end else if (dispatch) begin
      cmd_count <= cmd_count + 16'd1;
    end
  end

  // Drop counter saturates; a drop in the same cycle as a clear still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop) begin
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end else if (overrun_clr) begin
      drop_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Purpose : self-checking bench for jtag_debug_cmd_sync with an event-level reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_jtag_debug_cmd_sync;

  localparam int SRW = 38;
  localparam int IRW = 2;
  localparam int NC  = 4;
  localparam int S   = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           vs_uir = 1'b0;
  logic           vs_udr = 1'b0;
  logic [IRW-1:0] ir_in = '0;
  logic [SRW-1:0] sr = '0;
  logic           cmd_ready = 1'b0;
  logic           overrun_clr = 1'b0;
  logic [SRW-1:0] jdo;
  logic [IRW-1:0] jdo_ir;
  logic [NC-1:0]  take_action;
  logic [NC-1:0]  take_no_action;
  logic           cmd_pending;
  logic           overrun;
`ifdef JTAG_DEBUG_CMD_COUNT_EN
  logic [15:0]    cmd_count;
  logic [7:0]     drop_count;
`endif

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  jtag_debug_cmd_sync #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .SYNC_STAGES(S)) dut (
    .clk            (clk),
    .reset          (reset),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .overrun_clr    (overrun_clr),
    .jdo            (jdo),
    .jdo_ir         (jdo_ir),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .cmd_pending    (cmd_pending),
    .overrun        (overrun)
`ifdef JTAG_DEBUG_CMD_COUNT_EN
    ,
    .cmd_count      (cmd_count),
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a one-entry command slot fed by delayed strobe edges.
  logic [S+1:0]   uh, dh;   // input level history, [0] = newest sample
  bit             m_valid;
  logic [SRW-1:0] m_jdo;
  logic [IRW-1:0] m_ir, m_irq;
  logic [NC-1:0]  m_act, m_noact;
  bit             m_ov;
  logic [15:0]    m_cnt;
  logic [7:0]     m_drop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      uh = '0; dh = '0; m_valid = 0; m_jdo = '0; m_ir = '0; m_irq = '0;
      m_act = '0; m_noact = '0; m_ov = 0; m_cnt = '0; m_drop = '0;
    end else begin
      bit set_ov;
      set_ov = 0;
      uh = {uh[S:0], vs_uir};
      dh = {dh[S:0], vs_udr};
      m_act = '0;
      m_noact = '0;
      if (m_valid && cmd_ready) begin
        if (m_jdo[SRW-1]) m_act[m_ir] = 1'b1;
        else              m_noact[m_ir] = 1'b1;
        m_valid = 0;
        m_cnt = m_cnt + 16'd1;
      end
      if (dh[S] && !dh[S+1]) begin
        if (!m_valid) begin
          m_valid = 1; m_jdo = sr; m_ir = m_irq;
        end else begin
          m_ov = 1; set_ov = 1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
      end
      if (overrun_clr && !set_ov) begin
        m_ov = 0; m_drop = '0;
      end
      if (uh[S] && !uh[S+1]) m_irq = ir_in;
    end
  end

  always @(negedge clk) begin
    if (!reset && cmp_en) begin
      check("jdo",         64'(jdo),            64'(m_jdo));
      check("jdo_ir",      64'(jdo_ir),         64'(m_ir));
      check("take_action", 64'(take_action),    64'(m_act));
      check("take_no_act", 64'(take_no_action), 64'(m_noact));
      check("cmd_pending", 64'(cmd_pending),    64'(m_valid));
      check("overrun",     64'(overrun),        64'(m_ov));
`ifdef JTAG_DEBUG_CMD_COUNT_EN
      check("cmd_count",   64'(cmd_count),      64'(m_cnt));
      check("drop_count",  64'(drop_count),     64'(m_drop));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_ir(input logic [IRW-1:0] v);
    ir_in = v; vs_uir = 1'b1; step(1); vs_uir = 1'b0; step(S + 2);
  endtask

  task automatic pulse_udr(input logic [SRW-1:0] v);
    sr = v; vs_udr = 1'b1; step(1); vs_udr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_jdo"},     64'(jdo),            64'd0);
    check({tag, "_jdo_ir"},  64'(jdo_ir),         64'd0);
    check({tag, "_act"},     64'(take_action),    64'd0);
    check({tag, "_noact"},   64'(take_no_action), 64'd0);
    check({tag, "_pending"}, 64'(cmd_pending),    64'd0);
    check({tag, "_overrun"}, 64'(overrun),        64'd0);
  endtask

  // Asynchronous reset asserted away from any clock edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b1; #1;
    check_zero("rst");
    @(negedge clk); #2 reset = 1'b0;
  endtask

  initial begin
    #1 check_zero("por");
    step(2); #2 reset = 1'b0;
    cmp_en = 1'b1;
    step(4);

    // Basic dispatch with action bit set
    cmd_ready = 1'b1;
    load_ir(2'b01);
    sr = 38'h20_0000_1234; vs_udr = 1'b1;
    step(3);
    check("basic_jdo",      64'(jdo),         64'h20_0000_1234);
    check("basic_model",    64'(m_jdo),       64'h20_0000_1234);
    check("basic_pend",     64'(cmd_pending), 64'd1);
    check("basic_no_early", 64'(take_action), 64'd0);
    step(1);
    check("basic_pulse",    64'(take_action), 64'b0010);
    check("basic_model_p",  64'(m_act),       64'b0010);
    step(1);
    check("basic_one_cyc",  64'(take_action), 64'd0);
    step(6);
    check("level_held_one", 64'(cmd_pending), 64'd0);
    vs_udr = 1'b0; step(S + 2);

    // No-action command
    load_ir(2'b11);
    sr = 38'h00_0000_00AB; vs_udr = 1'b1;
    step(4);
    check("noact_pulse", 64'(take_no_action), 64'b1000);
    check("noact_act0",  64'(take_action),    64'd0);
    vs_udr = 1'b0; step(S + 3);

    // Back-pressure
    cmd_ready = 1'b0;
    load_ir(2'b10);
    pulse_udr(38'h3F_1111_2222);
    step(12);
    sr = 38'h01_2345_6789;
    check("bp_pending", 64'(cmd_pending), 64'd1);
    check("bp_jdo",     64'(jdo),         64'h3F_1111_2222);
    check("bp_nopulse", 64'(take_action | take_no_action), 64'd0);
    cmd_ready = 1'b1; step(1);
    check("bp_pulse",   64'(take_action), 64'b0100);
    check("bp_pend_lo", 64'(cmd_pending), 64'd0);
    step(1);
    check("bp_once",    64'(take_action), 64'd0);

    // Overrun, then overrun_clr coinciding with a third drop
    cmd_ready = 1'b0;
    pulse_udr(38'h31_AAAA_0001); step(S + 2);
    pulse_udr(38'h15_BBBB_0002); step(S + 2);
    check("ov_set", 64'(overrun), 64'd1);
    check("ov_jdo", 64'(jdo),     64'h31_AAAA_0001);
    sr = 38'h2C_CCCC_0003; vs_udr = 1'b1; step(1); vs_udr = 1'b0;
    step(S - 1);
    overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
    check("ov_set_wins", 64'(overrun), 64'd1);
    check("ov_jdo2",     64'(jdo),     64'h31_AAAA_0001);
    overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
    check("ov_cleared",  64'(overrun), 64'd0);
    cmd_ready = 1'b1; step(1);
    check("ov_dispatch", 64'(take_action), 64'b0100);
    step(2);

    // Capture on the dispatch cycle
    cmd_ready = 1'b0;
    pulse_udr(38'h25_0000_000D); step(S + 2);
    sr = 38'h05_0000_000E; vs_udr = 1'b1; step(1); vs_udr = 1'b0;
    step(S - 1);
    cmd_ready = 1'b1; step(1);
    check("sim_old_fires", 64'(take_action), 64'b0100);
    check("sim_jdo_new",   64'(jdo),         64'h05_0000_000E);
    check("sim_pending",   64'(cmd_pending), 64'd1);
    check("sim_no_ov",     64'(overrun),     64'd0);
    step(1);
    check("sim_second",    64'(take_no_action), 64'b0100);
    check("sim_idle",      64'(cmd_pending),    64'd0);

    // Reset while a command is pending
    cmd_ready = 1'b0;
    pulse_udr(38'h3A_5A5A_5A5A); step(S + 2);
    check("rp_pending", 64'(cmd_pending), 64'd1);
    do_reset();
    cmd_ready = 1'b1; step(3);
    check("rp_no_pulse", 64'(take_action | take_no_action), 64'd0);
    check("rp_idle",     64'(cmd_pending), 64'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) vs_uir = ~vs_uir;
      if ($urandom_range(0, 4) == 0) vs_udr = ~vs_udr;
      ir_in       = IRW'($urandom);
      sr          = SRW'({$urandom(), $urandom()});
      cmd_ready   = ($urandom_range(0, 2) != 0);
      overrun_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      else step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
